// File: rtl/ibex_cheri_tagged_mem_responder.sv
// ibex_cheri_tagged_mem_responder: Ibex data-bus SRAM with one CHERI tag bit per 8-byte granule
// Array effects happen at the grant edge; responses travel a fixed-depth shift pipeline.
module ibex_cheri_tagged_mem_responder #(
    parameter logic [31:0] MemBase        = 32'h0010_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_cap_i,
    input  logic        data_wtag_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_rtag_o,
    output logic        data_err_o
);
    localparam int unsigned AW = $clog2(MemWords);
    localparam logic [32:0] Lo = {1'b0, MemBase};
    localparam logic [32:0] Hi = Lo + 33'(4 * MemWords);

    logic [31:0]           mem [MemWords];
    logic [MemWords/2-1:0] tags;
    logic [2:0]            inflight;
    logic [Latency-1:0]    pv, pt, pe;
    logic [31:0]           pd [Latency];
    logic                  in_range, err, wr, rd;
    logic [AW-1:0]         idx;
    logic [AW-2:0]         gran;

    assign in_range = ({1'b0, data_addr_i} >= Lo) && ({1'b0, data_addr_i} < Hi);
    assign err      = !in_range || (data_cap_i && data_be_i != 4'hF);
    assign idx      = AW'((data_addr_i - MemBase) >> 2);
    assign gran     = idx[AW-1:1];
    // A response leaving this cycle frees its slot for a new grant in the same cycle
    assign data_gnt_o = rst_ni && data_req_i &&
                        ((inflight - {2'b0, data_rvalid_o}) < 3'(MaxOutstanding));
    assign wr = data_gnt_o && data_we_i && !err;
    assign rd = data_gnt_o && !data_we_i && !err;

    always_ff @(posedge clk_i) begin
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_cap_i || data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tags     <= '0;
            inflight <= '0;
        end else begin
            if (wr) tags[gran] <= data_cap_i && data_wtag_i;
            inflight <= inflight + {2'b0, data_gnt_o} - {2'b0, data_rvalid_o};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pt <= '0;
            pe <= '0;
            for (int i = 0; i < Latency; i++) pd[i] <= '0;
        end else begin
            pv[0] <= data_gnt_o;
            pd[0] <= rd ? mem[idx] : '0;
            pt[0] <= rd && data_cap_i && tags[gran];
            pe[0] <= data_gnt_o && err;
            for (int i = 1; i < Latency; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pt[i] <= pt[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    assign data_rvalid_o = pv[Latency-1];
    assign data_rdata_o  = pd[Latency-1];
    assign data_rtag_o   = pt[Latency-1];
    assign data_err_o    = pe[Latency-1];
endmodule

// File: tb/tb_ibex_cheri_tagged_mem_responder.sv
// tb_ibex_cheri_tagged_mem_responder: random and directed checks against a word/tag array model
module tb_ibex_cheri_tagged_mem_responder;
    localparam logic [31:0] Base  = 32'h0010_0000;
    localparam int          Words = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req1 = 0, we1 = 0, cap1 = 0, wtag1 = 0, gnt1, rv1, rt1, er1;
    logic [31:0] addr1 = 0, wdata1 = 0, rd1;
    logic [3:0]  be1 = 0;
    logic        req3 = 0, we3 = 0, cap3 = 0, wtag3 = 0, gnt3, rv3, rt3, er3;
    logic [31:0] addr3 = Base, wdata3 = 0, rd3;
    logic [3:0]  be3 = 4'hF;

    ibex_cheri_tagged_mem_responder #(.MemBase(Base), .MemWords(Words), .Latency(1), .MaxOutstanding(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1), .data_addr_i(addr1),
        .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1), .data_cap_i(cap1), .data_wtag_i(wtag1),
        .data_rvalid_o(rv1), .data_rdata_o(rd1), .data_rtag_o(rt1), .data_err_o(er1));

    ibex_cheri_tagged_mem_responder #(.MemBase(Base), .MemWords(Words), .Latency(3), .MaxOutstanding(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_gnt_o(gnt3), .data_addr_i(addr3),
        .data_we_i(we3), .data_be_i(be3), .data_wdata_i(wdata3), .data_cap_i(cap3), .data_wtag_i(wtag3),
        .data_rvalid_o(rv3), .data_rdata_o(rd3), .data_rtag_o(rt3), .data_err_o(er3));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    bit [31:0] m_mem [Words];
    bit        m_tag [Words/2];
    bit        ev, et, ee;
    bit [31:0] ed;

    // One dut1 cycle: check the response owed from the previous grant, then apply the current request
    task automatic step1();
        longint a;
        int idx;
        @(negedge clk);
        chk("gnt", gnt1, req1);
        chk("rvalid", rv1, ev);
        chk("rdata", rd1, ed);
        chk("rtag", rt1, et);
        chk("err", er1, ee);
        ev = req1; ed = 0; et = 0; ee = 0;
        if (req1) begin
            a   = longint'(addr1);
            ee  = a < longint'(Base) || a >= longint'(Base) + 4 * Words || (cap1 && be1 != 4'hF);
            idx = int'((a - longint'(Base)) / 4);
            if (!ee && we1) begin
                for (int b = 0; b < 4; b++) if (cap1 || be1[b]) m_mem[idx][8*b +: 8] = wdata1[8*b +: 8];
                m_tag[idx/2] = cap1 && wtag1;
            end else if (!ee) begin
                ed = m_mem[idx];
                et = cap1 && m_tag[idx/2];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [31:0] a, input bit we, input bit [3:0] be, input logic [31:0] wd,
                       input bit cap, input bit tg);
        req1 = 1; addr1 = a; we1 = we; be1 = be; wdata1 = wd; cap1 = cap; wtag1 = tg;
        step1();
        req1 = 0;
    endtask

    task automatic idle1();
        req1 = 0;
        step1();
    endtask

    initial begin
        bit [5:0] gpat;
        bit [9:0] vpat;
        bit       any;
        logic [31:0] a;
        req1 = 1; req3 = 1;
        #12;
        chk("reset_gnt1", gnt1, 0);
        chk("reset_gnt3", gnt3, 0);
        chk("reset_out1", {rv1, rt1, er1, rd1}, 0);
        chk("reset_out3", {rv3, rt3, er3, rd3}, 0);
        req1 = 0; req3 = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1;

        for (int i = 0; i < Words; i++) op1(Base + 4 * i, 1, 4'hF, $urandom, 0, 0);
        // tagged round trip and tag strip
        op1(Base, 1, 4'hF, 32'h1111_1111, 1, 1);
        op1(Base + 4, 1, 4'hF, 32'h2222_2222, 1, 1);
        op1(Base, 0, 4'hF, 0, 1, 0);
        op1(Base + 4, 0, 4'hF, 0, 1, 0);
        op1(Base + 4, 1, 4'b0001, 32'h0000_0033, 0, 0);
        op1(Base, 0, 4'hF, 0, 1, 0);
        op1(Base, 0, 4'hF, 0, 0, 0);
        // errors
        op1(32'h000F_FFFC, 0, 4'hF, 0, 0, 0);
        op1(32'h0010_1000, 1, 4'hF, 32'hDEAD_BEEF, 0, 0);
        op1(Base + 16, 1, 4'hF, 32'h5555_5555, 1, 1);
        op1(Base + 16, 1, 4'h3, 32'h6666_6666, 1, 0);
        op1(Base + 16, 0, 4'hF, 0, 1, 0);
        op1(32'hFFFF_FFFC, 0, 4'hF, 0, 0, 0);
        // byte lanes
        op1(Base + 32, 1, 4'hF, 0, 0, 0);
        op1(Base + 32, 1, 4'b1010, 32'hAABB_CCDD, 0, 0);
        op1(Base + 32, 0, 4'b0001, 0, 0, 0);
        idle1();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) begin
                idle1();
            end else begin
                case ($urandom_range(9))
                    0: a = Base - 4 * $urandom_range(1, 4);
                    1: a = Base + 4 * Words + 4 * $urandom_range(0, 3);
                    2: a = 32'hFFFF_FFFC;
                    default: a = Base + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                endcase
                op1(a, 1'($urandom), ($urandom_range(2) == 0) ? 4'hF : 4'($urandom), $urandom,
                    $urandom_range(2) == 0, 1'($urandom));
            end
        end
        op1(Base + 8, 1, 4'hF, 32'h7777_7777, 1, 1);
        op1(Base + 12, 1, 4'hF, 32'h8888_8888, 1, 1);
        idle1();

        // throttle on the Latency=3 / MaxOutstanding=2 instance
        req3 = 1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) req3 = 0;
            @(negedge clk);
            if (c < 6) gpat[c] = gnt3;
            vpat[c] = rv3;
            if (rv3) chk("err3", er3, 0);
            @(posedge clk) #1;
        end
        chk("gnt_pattern", gpat, 6'b011011);
        chk("rvalid_pattern", vpat, 10'b0011011000);

        // reset with two loads in flight
        req3 = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk) chk("gnt3_pre", gnt3, 1);
            @(posedge clk) #1;
        end
        req3 = 0;
        #2 rst_n = 0;
        req1 = 1; req3 = 1;
        #1;
        chk("gnt1_in_reset", gnt1, 0);
        chk("gnt3_in_reset", gnt3, 0);
        chk("out3_in_reset", {rv3, rt3, er3, rd3}, 0);
        repeat (2) @(posedge clk);
        req1 = 0; req3 = 0;
        ev = 0; ed = 0; et = 0; ee = 0;
        for (int i = 0; i < Words / 2; i++) m_tag[i] = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1;
        any = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk) any |= rv3;
            @(posedge clk) #1;
        end
        chk("rvalid3_after_reset", any, 0);
        for (int i = 0; i < 8; i++) op1(Base + 4 * i, 0, 4'hF, 0, 1, 0);
        idle1();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
